// File: rtl/aca_vl_ctrl_pkg.sv
// Shared definitions for the approximate-carry adder controller:
// datapath width, speculation window and controller state encoding.
package aca_vl_ctrl_pkg;

    localparam int ACA_W   = 8;   // adder width
    localparam int ACA_WIN = 4;   // carry look-back window in bits

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } aca_state_e;

endpackage

// File: rtl/ACA.sv
// Speculative (windowed-carry) adder. The carry into bit i is rebuilt from
// only the ACA_WIN bits below it; the global carry-in takes part only while
// the window still reaches down to bit 0.
module ACA
    import aca_vl_ctrl_pkg::*;
(
    input  logic [ACA_W-1:0] A,
    input  logic [ACA_W-1:0] B,
    input  logic             Cin,
    output logic [ACA_W-1:0] Sum,
    output logic             Cout
);

    logic [ACA_W:0] carry;
    logic           c_run;
    int             lo;

    // Rebuild each carry (and cout, as carry[ACA_W]) from its own short window
    always_comb begin
        carry    = '0;
        c_run    = 1'b0;
        lo       = 0;
        carry[0] = Cin;
        for (int i = 1; i <= ACA_W; i++) begin
            lo    = (i > ACA_WIN) ? (i - ACA_WIN) : 0;
            c_run = (lo == 0) ? Cin : 1'b0;
            for (int j = 0; j < ACA_W; j++) begin
                if ((j >= lo) && (j < i)) begin
                    c_run = (A[j] & B[j]) | (c_run & (A[j] ^ B[j]));
                end
            end
            carry[i] = c_run;
        end
    end

    assign Sum  = A ^ B ^ carry[ACA_W-1:0];
    assign Cout = carry[ACA_W];

endmodule

// File: rtl/aca_vl_ctrl.sv
// Controller around the speculative adder: accepts one operand set, checks
// the speculative result against the exact sum and either returns it or
// spends one extra cycle returning the exact value.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and data until that edge, and the
// result outputs stay frozen while out_valid is high and out_ready is low.
// Optional macro ACA_VL_CTRL_STATS_EN adds saturating op/error counters;
// without it op_cnt and err_cnt read as zero.
module aca_vl_ctrl
    import aca_vl_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_cin,
    input  logic             approx_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_cout,
    output logic             out_err,
    output logic             out_fixed,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output aca_state_e       dbg_state
);

    aca_state_e       state_q, state_d;
    logic [ACA_W-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d, approx_q, approx_d;
    logic [ACA_W-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, err_q, err_d, fixed_q, fixed_d;

    logic [ACA_W-1:0] spec_sum;
    logic             spec_cout;
    logic [ACA_W:0]   exact;
    logic             spec_err;
    logic             out_hs;

    ACA u_aca (
        .A    (a_q),
        .B    (b_q),
        .Cin  (cin_q),
        .Sum  (spec_sum),
        .Cout (spec_cout)
    );

    assign exact    = {1'b0, a_q} + {1'b0, b_q} + {{ACA_W{1'b0}}, cin_q};
    assign spec_err = ({spec_cout, spec_sum} != exact);
    assign out_hs   = (state_q == DONE) && out_ready;

    // Next-state and result-register loading for the IDLE/EVAL/FIX/DONE flow
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        approx_d = approx_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        err_d    = err_q;
        fixed_d  = fixed_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    cin_d    = in_cin;
                    approx_d = approx_mode;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                if (!spec_err || approx_q) begin
                    sum_d   = spec_sum;
                    cout_d  = spec_cout;
                    err_d   = spec_err;
                    fixed_d = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = FIX;
                end
            end
            FIX: begin
                sum_d   = exact[ACA_W-1:0];
                cout_d  = exact[ACA_W];
                err_d   = 1'b1;
                fixed_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers; reset drops any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            approx_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            fixed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            approx_q <= approx_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            fixed_q  <= fixed_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_err   = err_q;
    assign out_fixed = fixed_q;
    assign dbg_state = state_q;

`ifdef ACA_VL_CTRL_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] op_cnt_q, op_cnt_d, err_cnt_q, err_cnt_d;

    // Saturating counts of delivered results and of delivered erroneous results
    always_comb begin
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        if (out_hs) begin
            if (op_cnt_q != CNT_MAX) begin
                op_cnt_d = op_cnt_q + CNT_ONE;
            end
            if (err_q && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign op_cnt  = op_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign op_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_aca_vl_ctrl.sv
// Bench for aca_vl_ctrl: directed operand sets with hand-computed results,
// a result queue filled by the driver and drained by an output monitor.
module tb_aca_vl_ctrl;
    import aca_vl_ctrl_pkg::*;

    localparam int CNT_W = 2;
    localparam int EXP_W = 11;   // {sum[7:0], cout, err, fixed}

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic             in_cin = 1'b0;
    logic             approx_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_sum;
    logic             out_cout;
    logic             out_err;
    logic             out_fixed;
    logic [CNT_W-1:0] op_cnt;
    logic [CNT_W-1:0] err_cnt;
    aca_state_e       dbg_state;

    int errors = 0;
    int checks = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_got, mon_exp;
    logic [CNT_W-1:0] exp_op = '0;
    logic [CNT_W-1:0] exp_err = '0;

    aca_vl_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .approx_mode (approx_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_err     (out_err),
        .out_fixed   (out_fixed),
        .op_cnt      (op_cnt),
        .err_cnt     (err_cnt),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per output handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_op  = '0;
            exp_err = '0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_got = {out_sum, out_cout, out_err, out_fixed};
                mon_exp = exp_q.pop_front();
                check("result", {21'd0, mon_got}, {21'd0, mon_exp});
`ifdef ACA_VL_CTRL_STATS_EN
                check("op_cnt", {30'd0, op_cnt}, {30'd0, exp_op});
                check("err_cnt", {30'd0, err_cnt}, {30'd0, exp_err});
                if (exp_op != {CNT_W{1'b1}}) exp_op = exp_op + 1'b1;
                if (mon_exp[1] && (exp_err != {CNT_W{1'b1}})) exp_err = exp_err + 1'b1;
`else
                check("op_cnt", {30'd0, op_cnt}, 32'd0);
                check("err_cnt", {30'd0, err_cnt}, 32'd0);
`endif
            end
        end
    end

    // Driver: one operation, with latency and optional stall checks
    task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic approx,
                         input logic [7:0] es, input logic ec, input logic ee, input logic ef,
                         input int elat, input int stall);
        int n;
        logic [31:0] rnd;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        if (stall > 0) out_ready = 1'b0;
        in_a = a;
        in_b = b;
        in_cin = cin;
        approx_mode = approx;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({es, ec, ee, ef});
        in_valid = 1'b0;
        rnd = $urandom;
        in_a = rnd[7:0];
        in_b = rnd[15:8];
        in_cin = rnd[16];
        approx_mode = ~approx;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 10);
        check({name, "_latency"}, n, elat);
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                check({name, "_stall_hold"}, {21'd0, out_valid, out_sum, out_cout, out_err, out_fixed},
                      {21'd0, 1'b1, es, ec, ee, ef});
                check({name, "_stall_busy"}, {31'd0, in_ready}, 32'd0);
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Reset pulsed while an operation sits in FIX
    task automatic reset_in_fix();
        @(negedge clk);
        in_a = 8'h7F;
        in_b = 8'h01;
        in_cin = 1'b0;
        approx_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_state_fix", {30'd0, dbg_state}, {30'd0, FIX});
        rst_n = 1'b0;
        #1;
        check("rst_async_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        check("rst_valid_low", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_no_result", {31'd0, out_valid}, 32'd0);
            check("rst_ready", {31'd0, in_ready}, 32'd1);
        end
        check("rst_op_cnt", {30'd0, op_cnt}, 32'd0);
        check("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
    endtask

    // Main sequence
    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_outputs", {21'd0, out_sum, out_cout, out_err, out_fixed}, 32'd0);
        check("reset_counts", {28'd0, op_cnt, err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        do_op("clean_12_34",  8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1, 0);
        do_op("fix_7f_01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 2, 0);
        do_op("approx_7f_01", 8'h7F, 8'h01, 1'b0, 1'b1, 8'h60, 1'b0, 1'b1, 1'b0, 1, 0);
        do_op("stall_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2, 5);
        do_op("cout_80_80",   8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0);
        do_op("cin_0f_00",    8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1, 0);

        reset_in_fix();

        do_op("sat_1", 8'h7F, 8'h01, 1'b0, 1'b1, 8'h60, 1'b0, 1'b1, 1'b0, 1, 0);
        do_op("sat_2", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 2, 0);
        do_op("sat_3", 8'h1F, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1, 0);
        do_op("sat_4", 8'h1F, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b1, 2, 0);
        do_op("sat_5", 8'hFF, 8'h01, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b1, 1'b0, 1, 0);

        @(negedge clk);
`ifdef ACA_VL_CTRL_STATS_EN
        check("final_op_cnt", {30'd0, op_cnt}, 32'd3);
        check("final_err_cnt", {30'd0, err_cnt}, 32'd3);
`else
        check("final_op_cnt", {30'd0, op_cnt}, 32'd0);
        check("final_err_cnt", {30'd0, err_cnt}, 32'd0);
`endif
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aca_vl_ctrl.md
ACA_VL_CTRL -- requirements
Module: aca_vl_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the statistics counters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 in_a, in_b  input  8 each  addends.
REQ-007 in_cin  input  1  carry-in.
REQ-008 approx_mode  input  1  sampled at accept; 1 = return the speculative result even when it is wrong.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_sum  output  8  result sum.
REQ-012 out_cout  output  1  result carry-out.
REQ-013 out_err  output  1  the speculative result differed from the exact {cout,sum}.
REQ-014 out_fixed  output  1  the returned result is the exact, recovered value.
REQ-015 op_cnt, err_cnt  output  CNT_W each  statistics counters (see Configuration).

Function
REQ-016 States: IDLE, EVAL, FIX, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept on in_valid&&in_ready: register a, b, cin and approx_mode; go to EVAL.
REQ-018 EVAL: the 8-bit speculative adder runs on the registered operands.
  - Carry into bit i (and cout) comes only from bits max(0,i-4)..i-1.
  - cin counts only for carries into bits 1..4.
  - Exact result = a+b+cin, 9 bits.
  - err = spec{cout,sum} != exact{cout,sum}.
REQ-019 EVAL, err=0: load spec, out_err=0, out_fixed=0, go to DONE; out_valid rises 1 cycle after the accept edge.
REQ-020 EVAL, err=1 and approx latched=1: load spec, out_err=1, out_fixed=0, go to DONE (1-cycle latency).
REQ-021 EVAL, err=1 and approx latched=0: go to FIX; FIX loads exact, out_err=1, out_fixed=1, go to DONE; out_valid rises 2 cycles after the accept edge.
REQ-022 DONE: out_valid=1; outputs SHALL stay stable until out_valid&&out_ready; then go to IDLE.
  - No new accept in that cycle; back-to-back throughput is one operation per 3 (clean) or 4 (recovered) cycles.
REQ-023 The in_* inputs are ignored outside the accept cycle; a change while busy SHALL NOT affect the result in flight.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and clear all of the following:
  - out_valid, out_sum, out_cout, out_err, out_fixed, op_cnt, err_cnt;
  - all internal operand registers.
REQ-025 in_ready SHALL be 1 from the first edge after reset release.
REQ-026 Reset asserted mid-operation (EVAL/FIX/DONE) SHALL discard the operation without producing a result.

Configuration
REQ-027 Macro ACA_VL_CTRL_STATS_EN.
  - Defined: op_cnt increments on each output handshake; err_cnt increments on each output handshake with out_err=1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - Undefined: op_cnt and err_cnt are tied to 0 and no counter flops exist.

Structure
REQ-028 A shared package SHALL hold the state enum, ACA_W=8 and ACA_WIN=4.
REQ-029 The speculative adder SHALL be a separate sub-module named ACA, instantiated once.
  - Ports: A, B, Cin, Sum, Cout.
  - The exact adder stays inline in aca_vl_ctrl.

Verification
REQ-030 a=0x12, b=0x34, cin=0, approx=0 -> out_valid 1 cycle after accept; sum=0x46, cout=0, err=0, fixed=0.
REQ-031 a=0x7F, b=0x01, cin=0, approx=0 -> 2-cycle latency; sum=0x80, cout=0, err=1, fixed=1.
REQ-032 a=0x7F, b=0x01, approx=1 -> 1-cycle latency; sum=0x60, err=1, fixed=0.
REQ-033 a=0xFF, b=0x01, approx=0 with out_ready held low 5 cycles -> sum=0x00, cout=1, err=1 stable throughout; in_ready=0 until the handshake.
REQ-034 rst_n pulsed low during FIX -> out_valid never rises; in_ready=1 after release; counters=0.
REQ-035 With STATS_EN and CNT_W=2: 5 erroring ops -> op_cnt=3, err_cnt=3 (saturated); without the macro both read 0.
